mac_rr_sched: RTL and testbench

Round-robin scheduler that shares one `mul_fp52` multiply-add unit (res = a·2^ea · b·2^eb + c·2^ec) among `NREQ` requesters. It accepts at most one operand set per cycle over a valid/ready handshake and drives registered operands into the MAC. It tags each issued operation with the requester ID and returns the 20-bit result with that ID after the MAC latency. It sits between the requester-side datapath and a single `mul_fp52` instance.

---
 rtl/mac_rr_sched.sv | 142 ++++++++++++++
 tb/tb_mac_rr_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rr_sched.sv
// mac_rr_sched: round-robin front end for a single shared mul_fp52 multiply-add
// unit (res = a*2^ea * b*2^eb + c*2^ec).
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   en                grant enable
//   req_valid/ready   per-requester handshake; ready is a combinational one-hot grant
//   req_dat           per requester {c, b, a}, 7-bit two's complement each
//   req_exp           per requester {ec, eb, ea}, 2-bit unsigned each
//   op_*_dat/op_*_exp registered operands driven into the MAC
//   mac_res           MAC result, MAC_LAT register stages after op_*
//   rsp_valid/id/res  one-cycle result pulse tagged with the owning requester
//   done_cnt          free-running count of delivered responses (wraps)
module mac_rr_sched #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int MAC_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0][20:0] req_dat,
  input  logic [NREQ-1:0][5:0] req_exp,
  output logic [NREQ-1:0]      req_ready,
  output logic [6:0]           op_a_dat,
  output logic [6:0]           op_b_dat,
  output logic [6:0]           op_c_dat,
  output logic [1:0]           op_a_exp,
  output logic [1:0]           op_b_exp,
  output logic [1:0]           op_c_exp,
  input  logic [19:0]          mac_res,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [19:0]          rsp_res,
  output logic [15:0]          done_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic [6:0] c;
    logic [6:0] b;
    logic [6:0] a;
  } opd_t;

  typedef struct packed {
    logic [1:0] ec;
    logic [1:0] eb;
    logic [1:0] ea;
  } ope_t;

  logic [IW-1:0]   ptr, ptr_nxt, gidx, idx;
  logic [IW:0]     sum;
  logic [NREQ-1:0] grant;
  logic            found, accept;
  opd_t            sel_d;
  ope_t            sel_e;

  // Scan from ptr upward, wrapping; first valid requester wins. ptr < NREQ
  // and k < NREQ, so one conditional subtract is enough for the modulo.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      idx = sum[IW-1:0];
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  // Grant is masked by reset as well so nothing looks accepted while held.
  assign req_ready = (rst_n && en) ? grant : '0;
  assign accept    = |req_ready;
  assign ptr_nxt   = (gidx == IW'(NREQ-1)) ? '0 : gidx + 1'b1;
  assign sel_d     = opd_t'(req_dat[gidx]);
  assign sel_e     = ope_t'(req_exp[gidx]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      op_a_dat <= '0;
      op_b_dat <= '0;
      op_c_dat <= '0;
      op_a_exp <= '0;
      op_b_exp <= '0;
      op_c_exp <= '0;
    end else if (accept) begin
      ptr      <= ptr_nxt;
      op_a_dat <= sel_d.a;
      op_b_dat <= sel_d.b;
      op_c_dat <= sel_d.c;
      op_a_exp <= sel_e.ea;
      op_b_exp <= sel_e.eb;
      op_c_exp <= sel_e.ec;
    end
  end

  // Tag pipe tracks the MAC: stage 0 lines up with op_*, stage MAC_LAT with
  // mac_res. Stage 0 reloads every cycle so bubbles propagate as vld = 0.
  logic [MAC_LAT:0]           vld_pipe;
  logic [MAC_LAT:0][ID_W-1:0] id_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= accept;
      id_pipe[0]  <= ID_W'(gidx);
      for (int s = 1; s <= MAC_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_res   <= '0;
      done_cnt  <= '0;
    end else begin
      rsp_valid <= vld_pipe[MAC_LAT];
      if (vld_pipe[MAC_LAT]) begin
        rsp_id  <= id_pipe[MAC_LAT];
        rsp_res <= mac_res;
      end
      if (rsp_valid) done_cnt <= done_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mac_rr_sched.sv
// Bench for mac_rr_sched with a behavioural one-stage mul_fp52 model. Every
// cycle goes through step(): it checks req_ready against a reference
// arbiter, pushes the expected {id, result} on accept, and pops/compares on
// each rsp_valid.
module tb_mac_rr_sched;
  localparam int NREQ = 4, ID_W = 2, MAC_LAT = 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0, en = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0][20:0] req_dat = '0;
  logic [NREQ-1:0][5:0]  req_exp = '0;
  logic [NREQ-1:0]       req_ready;
  logic [6:0]            op_a_dat, op_b_dat, op_c_dat;
  logic [1:0]            op_a_exp, op_b_exp, op_c_exp;
  logic [19:0]           mac_res = '0;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [19:0]           rsp_res;
  logic [15:0]           done_cnt;

  mac_rr_sched #(.NREQ(NREQ), .ID_W(ID_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_dat(req_dat), .req_exp(req_exp), .req_ready(req_ready),
    .op_a_dat(op_a_dat), .op_b_dat(op_b_dat), .op_c_dat(op_c_dat),
    .op_a_exp(op_a_exp), .op_b_exp(op_b_exp), .op_c_exp(op_c_exp),
    .mac_res(mac_res), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_res(rsp_res),
    .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] fmac(input logic [6:0] a, b, c, input logic [1:0] ea, eb, ec);
    int av, bv, cv, r;
    av = $signed(a);
    bv = $signed(b);
    cv = $signed(c);
    r  = (av * (1 << ea)) * (bv * (1 << eb)) + cv * (1 << ec);
    return r[19:0];
  endfunction

  // Behavioural MAC with MAC_LAT = 1.
  always @(posedge clk)
    mac_res <= fmac(op_a_dat, op_b_dat, op_c_dat, op_a_exp, op_b_exp, op_c_exp);

  int errors = 0, checks = 0;
  int ref_ptr = 0, last_gnt = -1, rsp_count = 0;
  logic [ID_W+19:0] exp_q[$];

  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input logic e, r, input int p);
    model_grant = '0;
    if (e && r)
      for (int k = 0; k < NREQ; k++)
        if (v[(p + k) % NREQ]) begin
          model_grant[(p + k) % NREQ] = 1'b1;
          return model_grant;
        end
  endfunction

  task automatic step();
    logic [NREQ-1:0]  eg;
    logic [ID_W+19:0] e;
    @(negedge clk);
    if (rsp_valid === 1'b1) begin
      checks++;
      rsp_count++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d res=%h, want no response", rsp_id, rsp_res);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_id, rsp_res} !== e) begin
          errors++;
          $display("FAIL rsp_data: got id=%0d res=%h, want id=%0d res=%h",
                   rsp_id, rsp_res, e[ID_W+19:20], e[19:0]);
        end
      end
    end
    eg = model_grant(req_valid, en, rst_n, ref_ptr);
    checks++;
    if (req_ready !== eg) begin
      errors++;
      $display("FAIL req_ready: got %b want %b", req_ready, eg);
    end
    last_gnt = -1;
    for (int i = 0; i < NREQ; i++)
      if (eg[i]) begin
        last_gnt = i;
        exp_q.push_back({ID_W'(i), fmac(req_dat[i][6:0], req_dat[i][13:7], req_dat[i][20:14],
                                        req_exp[i][1:0], req_exp[i][3:2], req_exp[i][5:4])});
        ref_ptr = (i + 1) % NREQ;
      end
    if (!rst_n) ref_ptr = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) begin
      req_dat[i] = 21'($urandom);
      req_exp[i] = 6'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    step();
    step();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({op_a_dat, op_b_dat, op_c_dat, op_a_exp, op_b_exp, op_c_exp} !== '0) begin
      errors++;
      $display("FAIL reset_ops: got %h want 0", {op_a_dat, op_b_dat, op_c_dat, op_a_exp, op_b_exp, op_c_exp});
    end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++;
    if ({rsp_id, rsp_res} !== '0) begin errors++; $display("FAIL reset_rsp: got id=%0d res=%h want 0", rsp_id, rsp_res); end
    checks++;
    if (done_cnt !== 16'd0) begin errors++; $display("FAIL reset_done_cnt: got %h want 0", done_cnt); end
  endtask

  task automatic test_single();
    req_dat[2] = {7'd7, 7'h7B, 7'd3};
    req_exp[2] = {2'd2, 2'd0, 2'd1};
    req_valid  = 4'b0100;
    step();
    checks++;
    if (last_gnt != 2) begin errors++; $display("FAIL single_grant: got %0d want 2", last_gnt); end
    req_valid = '0;
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early: got rsp_valid=%b want 0", rsp_valid); end
    step();
    checks++;
    if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 2'd2, 20'hFFFFE}) begin
      errors++;
      $display("FAIL single_rsp: got v=%b id=%0d res=%h want v=1 id=2 res=ffffe", rsp_valid, rsp_id, rsp_res);
    end
    step();
    checks++;
    if ({rsp_valid, done_cnt} !== {1'b0, 16'd1}) begin
      errors++;
      $display("FAIL single_done: got v=%b cnt=%0d want v=0 cnt=1", rsp_valid, done_cnt);
    end
  endtask

  task automatic test_extreme();
    req_dat[0] = {7'h3F, 7'h40, 7'h40};
    req_exp[0] = {2'd3, 2'd3, 2'd3};
    req_valid  = 4'b0001;
    step();
    req_valid = '0;
    step();
    step();
    checks++;
    if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 2'd0, 20'h401F8}) begin
      errors++;
      $display("FAIL extreme_rsp: got v=%b id=%0d res=%h want v=1 id=0 res=401f8", rsp_valid, rsp_id, rsp_res);
    end
    step();
  endtask

  task automatic test_fair();
    do_reset();
    req_valid = '1;
    for (int n = 0; n < 12; n++) begin
      rand_data();
      step();
      checks++;
      if (last_gnt != n % NREQ) begin errors++; $display("FAIL fair_grant%0d: got %0d want %0d", n, last_gnt, n % NREQ); end
    end
    req_valid = '0;
    for (int n = 0; n < 3; n++) step();
    checks++;
    if (done_cnt !== 16'd12) begin errors++; $display("FAIL fair_done: got %0d want 12", done_cnt); end
  endtask

  task automatic test_sparse();
    int exp_seq[7] = '{3, 1, 3, 1, 3, 0, 1};
    req_valid = 4'b0010;        // lone grant to 1 leaves ptr at 2
    step();
    req_valid = 4'b1010;
    for (int n = 0; n < 7; n++) begin
      if (n == 5) req_valid = 4'b1011;
      rand_data();
      step();
      checks++;
      if (last_gnt != exp_seq[n]) begin errors++; $display("FAIL sparse_grant%0d: got %0d want %0d", n, last_gnt, exp_seq[n]); end
    end
    req_valid = '0;
    for (int n = 0; n < 3; n++) step();
  endtask

  task automatic test_en();
    int rc0;
    req_valid = '1;
    rand_data();
    step();                     // ptr was 2: grants 2 then 3
    step();
    checks++;
    if (last_gnt != 3) begin errors++; $display("FAIL en_pre_grant: got %0d want 3", last_gnt); end
    en  = 1'b0;
    rc0 = rsp_count;
    for (int n = 0; n < 5; n++) step();
    checks++;
    if (rsp_count - rc0 != 2) begin errors++; $display("FAIL en_drain: got %0d responses want 2", rsp_count - rc0); end
    en = 1'b1;
    step();
    checks++;
    if (last_gnt != 0) begin errors++; $display("FAIL en_resume: got %0d want 0", last_gnt); end
    req_valid = '0;
    for (int n = 0; n < 3; n++) step();
  endtask

  task automatic test_reset_mid();
    int rc0;
    req_valid = '1;
    rand_data();
    step();
    step();
    rc0 = rsp_count;
    do_reset();
    checks++;
    if ({op_a_dat, op_b_dat, op_c_dat, op_a_exp, op_b_exp, op_c_exp, rsp_valid, rsp_id, rsp_res, done_cnt} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got ops=%h v=%b id=%0d res=%h cnt=%0d want all 0",
               {op_a_dat, op_b_dat, op_c_dat, op_a_exp, op_b_exp, op_c_exp}, rsp_valid, rsp_id, rsp_res, done_cnt);
    end
    for (int n = 0; n < 4; n++) step();
    checks++;
    if (rsp_count != rc0) begin errors++; $display("FAIL midreset_stale: got %0d stale responses want 0", rsp_count - rc0); end
  endtask

  task automatic test_wrap();
    req_valid = '1;
    for (int n = 0; n < 65535; n++) begin
      rand_data();
      step();
    end
    req_valid = '0;
    for (int n = 0; n < 3; n++) step();
    checks++;
    if (done_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_full: got %h want ffff", done_cnt); end
    req_valid = '1;
    rand_data();
    step();
    req_valid = '0;
    for (int n = 0; n < 3; n++) step();
    checks++;
    if (done_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extreme();
    test_fair();
    test_sparse();
    test_en();
    test_reset_mid();
    test_wrap();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover: got %0d pending want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
